lsu_mem_ctrl: RTL and testbench

//  Load/store sequencer between the core's memory stage and the data-memory port. Accepts one

---
 rtl/lsu_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the core memory stage and the data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses at acceptance with bus_err.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [3:0]  req_mem_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYCLES);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic        is_store_q;
    logic [3:0]  rw_q;
    logic [31:0] addr_q, wdata_q;
    logic [4:0]  rd_q;
    logic        misaligned, timeout;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (req_mem_rw == 4'd0 && req_addr[1:0] != 2'b00) ||
                        ((req_mem_rw == 4'd1 || (!req_is_store && req_mem_rw == 4'd3)) && req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // A response in the same cycle as the timeout wins: the data is already here.
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == TO_CNT && !mem_resp_valid;

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_we    = !is_store_q ? 4'b0000 :
                       rw_q == 4'd0 ? 4'b1111 :
                       rw_q == 4'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                       rw_q == 4'd2 ? 4'b0001 << addr_q[1:0] : 4'b0000;
    assign mem_wdata = rw_q == 4'd1 ? {2{wdata_q[15:0]}} :
                       rw_q == 4'd2 ? {4{wdata_q[7:0]}} : wdata_q;

    assign lb        = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lh        = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign load_data = rw_q == 4'd0 ? mem_rdata :
                       rw_q == 4'd1 ? {{16{lh[15]}}, lh} :
                       rw_q == 4'd2 ? {{24{lb[7]}}, lb} :
                       rw_q == 4'd3 ? {16'b0, lh} :
                       rw_q == 4'd4 ? {24'b0, lb} : 32'b0;

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        done          = 1'b0;
        wb_en         = 1'b0;
        bus_err       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_nx  = req_valid ? (misaligned ? ERR : ISSUE) : IDLE;
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                state_nx      = mem_req_ready ? WAIT : ISSUE;
            end
            WAIT: begin
                bus_err  = timeout;
                state_nx = mem_resp_valid ? DONE : timeout ? IDLE : WAIT;
            end
            DONE: begin
                done     = 1'b1;
                wb_en    = !is_store_q && rd_q != 5'd0;
                state_nx = IDLE;
            end
            default: begin
                bus_err  = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_store_q <= 1'b0;
            rw_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            state <= state_nx;
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 8'd1;
            if (state == IDLE && req_valid) begin
                is_store_q <= req_is_store;
                rw_q       <= req_mem_rw;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
            end
            if (state == WAIT && mem_resp_valid && !is_store_q) begin
                wb_rd   <= rd_q;
                wb_data <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench with a transaction-level expectation model for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, req_is_store;
    logic [3:0]  req_mem_rw;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        done, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;

    int n_cmp = 0, n_bad = 0;
    logic        chk_on = 1'b0;
    logic        e_ready, e_mvalid, e_done, e_wb_en, e_err, e_store, e_wbchk;
    logic [31:0] e_addr, e_wdata, e_wb_data;
    logic [3:0]  e_we;
    logic [4:0]  e_wb_rd;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_mem_rw(req_mem_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .done(done), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_we(input logic st, input logic [3:0] rw, input logic [31:0] a);
        if (!st) return 4'b0000;
        case (rw)
            4'd0:    return 4'b1111;
            4'd1:    return 4'(32'd3 << (2 * ((a / 2) % 2)));
            4'd2:    return 4'(32'd1 << (a % 4));
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [3:0] rw, input logic [31:0] d);
        case (rw)
            4'd1:    return (d % 32'h10000) * 32'h0001_0001;
            4'd2:    return (d % 32'h100) * 32'h0101_0101;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] rw, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) % 32'h100;
        h = (r >> (16 * ((a / 2) % 2))) % 32'h10000;
        case (rw)
            4'd0:    return r;
            4'd1:    return h >= 32'h8000 ? h - 32'h10000 : h;
            4'd2:    return b >= 32'h80 ? b - 32'h100 : b;
            4'd3:    return h;
            4'd4:    return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_mis(input logic st, input logic [3:0] rw, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (rw == 4'd0) return a % 4 != 0;
        if (rw == 4'd1 || (!st && rw == 4'd3)) return a % 2 != 0;
`endif
        return 1'b0;
    endfunction

    task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        cmp("req_ready", 32'(req_ready), 32'(e_ready));
        cmp("mem_req_valid", 32'(mem_req_valid), 32'(e_mvalid));
        cmp("done", 32'(done), 32'(e_done));
        cmp("wb_en", 32'(wb_en), 32'(e_wb_en));
        cmp("bus_err", 32'(bus_err), 32'(e_err));
        if (e_mvalid) begin
            cmp("mem_addr", mem_addr, e_addr);
            cmp("mem_we", 32'(mem_we), 32'(e_we));
            if (e_store) cmp("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_wbchk) begin
            cmp("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
            cmp("wb_data", wb_data, e_wb_data);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_c(input logic r, input logic v, input logic d, input logic w, input logic e);
        e_ready = r; e_mvalid = v; e_done = d; e_wb_en = w; e_err = e;
    endtask

    task automatic idle(input int n, input logic resp);
        mem_resp_valid = resp;
        for (int i = 0; i < n; i++) begin
            expect_c(1, 0, 0, 0, 0);
            step;
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs;
        cmp("rst req_ready", 32'(req_ready), 32'd1);
        cmp("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        cmp("rst mem_addr", mem_addr, 32'd0);
        cmp("rst mem_we", 32'(mem_we), 32'd0);
        cmp("rst mem_wdata", mem_wdata, 32'd0);
        cmp("rst done", 32'(done), 32'd0);
        cmp("rst wb_en", 32'(wb_en), 32'd0);
        cmp("rst wb_rd", 32'(wb_rd), 32'd0);
        cmp("rst wb_data", wb_data, 32'd0);
        cmp("rst bus_err", 32'(bus_err), 32'd0);
    endtask

    // resp_lag: WAIT cycles before the response; -1 never responds, -2 leaves the DUT in WAIT.
    task automatic access(input logic st, input logic [3:0] rw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int rdy_lag,
                          input int resp_lag, input logic [31:0] rdata);
        logic mis;
        mis = exp_mis(st, rw, addr);
        req_valid = 1'b1; req_is_store = st; req_mem_rw = rw;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        expect_c(1, 0, 0, 0, 0);
        step;
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_rd = ~rd; req_mem_rw = ~rw;
        if (mis) begin
            expect_c(0, 0, 0, 0, 1);
            step;
            return;
        end
        e_addr = addr - addr % 4; e_we = exp_we(st, rw, addr); e_wdata = exp_wd(rw, wd); e_store = st;
        for (int i = 0; i <= rdy_lag; i++) begin
            mem_req_ready = (i == rdy_lag);
            mem_resp_valid = (i != rdy_lag);
            expect_c(0, 1, 0, 0, 0);
            step;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        for (int w = 0; w <= TO; w++) begin
            if (resp_lag == -2 && w == 2) return;
            if (w == resp_lag) begin
                mem_resp_valid = 1'b1; mem_rdata = rdata;
                expect_c(0, 0, 0, 0, 0);
                step;
                break;
            end
            mem_rdata = 32'h5A5A_5A5A;
            if (w == TO) begin
                expect_c(0, 0, 0, 0, 1);
                step;
                return;
            end
            expect_c(0, 0, 0, 0, 0);
            step;
        end
        mem_resp_valid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        expect_c(0, 0, 1, !st && rd != 5'd0, 0);
        e_wbchk = !st; e_wb_rd = rd; e_wb_data = exp_load(rw, addr, rdata);
        step;
        e_wbchk = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_mem_rw = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        e_store = 1'b0; e_wbchk = 1'b0; e_addr = '0; e_we = '0; e_wdata = '0; e_wb_rd = '0; e_wb_data = '0;
        expect_c(1, 0, 0, 0, 0);
        cmp("model LB", exp_load(4'd2, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
        cmp("model SH we", 32'(exp_we(1'b1, 4'd1, 32'h22)), 32'b1100);
        cmp("model SH wdata", exp_wd(4'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
        cmp("model LHU", exp_load(4'd3, 32'h2, 32'h9000_0001), 32'h0000_9000);
        cmp("model LH", exp_load(4'd1, 32'h41, 32'h1234_8001), 32'hFFFF_8001);
        cmp("model SB we", 32'(exp_we(1'b1, 4'd2, 32'h13)), 32'b1000);
        #3;
        chk_reset_outputs();
        step;
        rst = 1'b0;
        chk_on = 1'b1;
        idle(2, 1'b0);
        access(1'b0, 4'd2, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000);
        access(1'b1, 4'd1, 32'h22, 32'h1234_ABCD, 5'd7, 0, 1, 32'h0);
        access(1'b0, 4'd3, 32'h2, 32'h0, 5'd3, 3, 0, 32'h9000_0001);
        access(1'b0, 4'd0, 32'h10, 32'h0, 5'd8, 0, -1, 32'h0);
        idle(2, 1'b1);
        access(1'b0, 4'd0, 32'h14, 32'h0, 5'd9, 1, 3, 32'hCAFE_F00D);
        access(1'b0, 4'd1, 32'h41, 32'h0, 5'd4, 0, 0, 32'h1234_8001);
        idle(1, 1'b0);
        access(1'b1, 4'd2, 32'h13, 32'h0000_00AB, 5'd0, 0, 0, 32'h0);
        access(1'b1, 4'd0, 32'h2C, 32'hDEAD_BEEF, 5'd1, 2, 2, 32'h0);
        access(1'b0, 4'd4, 32'h1, 32'h0, 5'd31, 0, 0, 32'h0000_F100);
        access(1'b0, 4'd2, 32'h2, 32'h0, 5'd12, 0, 0, 32'h0071_0000);
        access(1'b0, 4'd5, 32'h0, 32'h0, 5'd13, 0, 0, 32'hFFFF_FFFF);
        access(1'b0, 4'd0, 32'h80, 32'h0, 5'd14, 0, -2, 32'h0);
        chk_on = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        step;
        rst = 1'b0;
        expect_c(1, 0, 0, 0, 0);
        chk_on = 1'b1;
        idle(2, 1'b1);
        access(1'b0, 4'd0, 32'h84, 32'h0, 5'd0, 0, 0, 32'h7654_3210);
        idle(2, 1'b0);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
